// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Control FSM for the nibble-processor front end.  It sequences the PC
// counter, the program ROM and the fetch register so that each instruction
// goes through FETCH, DECODE and then EXEC or JUMP, in program order.
//
// Jumps are two bytes long.  The jump target is {oprnd, second byte}.  The
// second byte is read straight from program_byte during DECODE, because the
// PC already points at it by then.  The jump condition comes from c_flag and
// z_flag, and the flags are sampled only in DECODE.
//
// Optional feature: define SINGLE_STEP_EN to enable single-step operation.
// When it is enabled, a step pulse in IDLE with run=0 executes exactly one
// instruction and then returns to IDLE.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   run           in   level; 1 = run, 0 = stop at the next instruction boundary
//   step          in   single-step request pulse (used only with SINGLE_STEP_EN)
//   instr         in   fetch register opcode nibble
//   oprnd         in   fetch register operand nibble
//   program_byte  in   ROM data at the current PC
//   c_flag        in   ALU carry flag
//   z_flag        in   ALU zero flag
//   enCounter     out  PC increment enable
//   enFetch       out  fetch register capture enable
//   load          out  PC load enable
//   counter12bit  out  PC load value (latched jump target)
//   exec_en       out  one-cycle execute strobe
//   halted        out  high while in HALT
//   state_dbg     out  current state encoding
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int          ADDR_W   = 12,
    parameter logic [3:0]  OPC_JC   = 4'h0,
    parameter logic [3:0]  OPC_JNC  = 4'h1,
    parameter logic [3:0]  OPC_JZ   = 4'h2,
    parameter logic [3:0]  OPC_JNZ  = 4'h3,
    parameter logic [3:0]  OPC_JMP  = 4'h4,
    parameter logic [3:0]  OPC_HALT = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [3:0]        instr,
    input  logic [3:0]        oprnd,
    input  logic [7:0]        program_byte,
    input  logic              c_flag,
    input  logic              z_flag,
    output logic              enCounter,
    output logic              enFetch,
    output logic              load,
    output logic [ADDR_W-1:0] counter12bit,
    output logic              exec_en,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_JUMP   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic                taken_reg, taken_next;
    logic                step_mode_reg, step_mode_next;
    logic [ADDR_W-1:0]   target_reg, target_next;
    logic                is_jump;
    logic                jump_cond;

    logic                en_counter_reg;
    logic                en_fetch_reg;
    logic                load_reg;
    logic                exec_en_reg;
    logic                halted_reg;

`ifndef SINGLE_STEP_EN
    // step has no function in this build.
    logic unused_step;
    assign unused_step = step;
`endif

    // Decode the opcode and evaluate the jump condition.
    always_comb begin
        is_jump   = 1'b0;
        jump_cond = 1'b0;
        case (instr)
            OPC_JC:  begin is_jump = 1'b1; jump_cond = c_flag;  end
            OPC_JNC: begin is_jump = 1'b1; jump_cond = !c_flag; end
            OPC_JZ:  begin is_jump = 1'b1; jump_cond = z_flag;  end
            OPC_JNZ: begin is_jump = 1'b1; jump_cond = !z_flag; end
            OPC_JMP: begin is_jump = 1'b1; jump_cond = 1'b1;    end
            default: begin is_jump = 1'b0; jump_cond = 1'b0;    end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        taken_next     = taken_reg;
        step_mode_next = step_mode_reg;
        target_next    = target_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    state_next     = ST_FETCH;
                    step_mode_next = 1'b0;
                end
`ifdef SINGLE_STEP_EN
                else if (step) begin
                    state_next     = ST_FETCH;
                    step_mode_next = 1'b1;
                end
`endif
            end
            ST_FETCH: state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_jump) begin
                    // The PC already points at the second jump byte.
                    target_next = ADDR_W'({oprnd, program_byte});
                    taken_next  = jump_cond;
                    state_next  = ST_JUMP;
                end else if (instr == OPC_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC, ST_JUMP: begin
                // A single-stepped instruction always returns to IDLE.
                state_next = (run && !step_mode_reg) ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // The outputs are registered from the next state, so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            taken_reg      <= 1'b0;
            step_mode_reg  <= 1'b0;
            target_reg     <= '0;
            en_counter_reg <= 1'b0;
            en_fetch_reg   <= 1'b0;
            load_reg       <= 1'b0;
            exec_en_reg    <= 1'b0;
            halted_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            taken_reg      <= taken_next;
            step_mode_reg  <= step_mode_next;
            target_reg     <= target_next;
            en_fetch_reg   <= (state_next == ST_FETCH);
            // When a jump is not taken, the PC is advanced past the second
            // byte.  load and enCounter are never asserted together.
            en_counter_reg <= (state_next == ST_FETCH) ||
                              ((state_next == ST_JUMP) && !taken_next);
            load_reg       <= (state_next == ST_JUMP) && taken_next;
            exec_en_reg    <= (state_next == ST_EXEC);
            halted_reg     <= (state_next == ST_HALT);
        end
    end

    assign enCounter    = en_counter_reg;
    assign enFetch      = en_fetch_reg;
    assign load         = load_reg;
    assign counter12bit = target_reg;
    assign exec_en      = exec_en_reg;
    assign halted       = halted_reg;
    assign state_dbg    = state_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [7:0]  program_byte;
    logic        c_flag;
    logic        z_flag;
    logic        enCounter;
    logic        enFetch;
    logic        load;
    logic [11:0] counter12bit;
    logic        exec_en;
    logic        halted;
    logic [2:0]  state_dbg;

    // Front-end environment: PC counter, program ROM and fetch register.
    logic [7:0]  rom [0:4095];
    logic [11:0] pc;
    logic [7:0]  fetch_q;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .step         (step),
        .instr        (instr),
        .oprnd        (oprnd),
        .program_byte (program_byte),
        .c_flag       (c_flag),
        .z_flag       (z_flag),
        .enCounter    (enCounter),
        .enFetch      (enFetch),
        .load         (load),
        .counter12bit (counter12bit),
        .exec_en      (exec_en),
        .halted       (halted),
        .state_dbg    (state_dbg)
    );

    always @(posedge clk) begin
        if (reset)          pc <= 12'h000;
        else if (load)      pc <= counter12bit;
        else if (enCounter) pc <= pc + 12'h001;
        if (reset)          fetch_q <= 8'h00;
        else if (enFetch)   fetch_q <= rom[pc];
    end

    assign program_byte = rom[pc];
    assign instr        = fetch_q[7:4];
    assign oprnd        = fetch_q[3:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: exec strobes are tagged 1 and carry {instr,oprnd}; loads
    // are tagged 2 and carry the target address.
    always @(negedge clk) begin
        if (exec_en || load) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {30'd0, exec_en, load}, 32'd0);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (exec_en) chk("sb_exec", {16'd0, 4'h1, 4'h0, instr, oprnd}, {16'd0, e});
                else         chk("sb_load", {16'd0, 4'h2, counter12bit}, {16'd0, e});
            end
            if (load) chk("load_and_count", {31'd0, enCounter}, 32'd0);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
        chk({tag, "_strobes"}, {27'd0, enCounter, enFetch, load, exec_en, halted}, 32'd0);
        chk({tag, "_counter"}, {20'd0, counter12bit}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        reset = 1'b1; run = 1'b0; step = 1'b0; c_flag = 1'b0; z_flag = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk_quiet("reset_init");

        // Plain instruction: three cycles, exec_en in the third.
        rom[0] = 8'h5A;
        sb.push_back({4'h1, 4'h0, 8'h5A});
        run = 1'b1;
        cyc();
        chk("t2_fetch_state", {29'd0, state_dbg}, 32'd1);
        chk("t2_fetch_strobes", {29'd0, enFetch, enCounter, load}, {29'd0, 3'b110});
        cyc();
        chk("t2_decode_state", {29'd0, state_dbg}, 32'd2);
        chk("t2_decode_instr", {24'd0, instr, oprnd}, 32'h5A);
        chk("t2_decode_pc", {20'd0, pc}, 32'h001);
        cyc();
        chk("t2_exec_state", {29'd0, state_dbg}, 32'd3);
        chk("t2_exec_en", {31'd0, exec_en}, 32'd1);
        chk("t2_exec_pc", {20'd0, pc}, 32'h001);
        run = 1'b0;
        cyc();
        chk("t2_idle_state", {29'd0, state_dbg}, 32'd0);
        chk("t2_idle_exec", {31'd0, exec_en}, 32'd0);

        // Unconditional jump to 0x123, then a stop requested during DECODE.
        do_reset();
        rom[0] = 8'h41; rom[1] = 8'h23; rom[12'h123] = 8'h5B;
        sb.push_back({4'h2, 12'h123});
        sb.push_back({4'h1, 4'h0, 8'h5B});
        run = 1'b1;
        cyc(); cyc();
        chk("t3_decode_instr", {24'd0, instr, oprnd}, 32'h41);
        cyc();
        chk("t3_jump_state", {29'd0, state_dbg}, 32'd4);
        chk("t3_jump_strobes", {30'd0, load, enCounter}, {30'd0, 2'b10});
        chk("t3_jump_target", {20'd0, counter12bit}, 32'h123);
        cyc();
        chk("t3_fetch_pc", {20'd0, pc}, 32'h123);
        chk("t3_fetch_en", {31'd0, enFetch}, 32'd1);
        cyc();
        chk("t3_decode2_instr", {24'd0, instr, oprnd}, 32'h5B);
        run = 1'b0;
        cyc();
        chk("t5_exec_completes", {31'd0, exec_en}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_idle_state", {29'd0, state_dbg}, 32'd0);
            chk("t5_no_fetch", {31'd0, enFetch}, 32'd0);
        end
        chk("t5_pc", {20'd0, pc}, 32'h124);

        // Reset asserted in the middle of an EXEC cycle.
        rom[12'h124] = 8'h6C;
        sb.push_back({4'h1, 4'h0, 8'h6C});
        run = 1'b1;
        cyc(); cyc(); cyc();
        chk("t1_pre_exec_state", {29'd0, state_dbg}, 32'd3);
        reset = 1'b1;
        run = 1'b0;
        cyc();
        chk_quiet("t1_reset_mid_exec");
        reset = 1'b0;

        // JC not taken: skip the second byte, then HALT at 0x002.
        rom[0] = 8'h07; rom[1] = 8'hFF; rom[2] = 8'hF0;
        c_flag = 1'b0;
        run = 1'b1;
        cyc(); cyc(); cyc();
        chk("t4n_jump_state", {29'd0, state_dbg}, 32'd4);
        chk("t4n_jump_strobes", {30'd0, load, enCounter}, {30'd0, 2'b01});
        chk("t4n_jump_target", {20'd0, counter12bit}, 32'h7FF);
        cyc();
        chk("t4n_fetch_pc", {20'd0, pc}, 32'h002);
        cyc(); cyc();
        chk("t6_halt_state", {29'd0, state_dbg}, 32'd5);
        chk("t6_halted", {31'd0, halted}, 32'd1);
        run = 1'b0;
        cyc();
        run = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        chk("t6_halt_sticky", {29'd0, state_dbg}, 32'd5);
        chk("t6_halt_strobes", {28'd0, halted, enFetch, enCounter, exec_en}, {28'd0, 4'b1000});
        chk("t6_halt_pc", {20'd0, pc}, 32'h003);

        // JC taken: load 0x7FF, stop at the boundary.
        run = 1'b0;
        do_reset();
        chk("t4t_reset_state", {29'd0, state_dbg}, 32'd0);
        sb.push_back({4'h2, 12'h7FF});
        c_flag = 1'b1;
        run = 1'b1;
        cyc(); cyc(); cyc();
        chk("t4t_jump_strobes", {30'd0, load, enCounter}, {30'd0, 2'b10});
        chk("t4t_jump_target", {20'd0, counter12bit}, 32'h7FF);
        c_flag = 1'b0;
        run = 1'b0;
        cyc();
        chk("t4t_idle_state", {29'd0, state_dbg}, 32'd0);
        chk("t4t_pc", {20'd0, pc}, 32'h7FF);

        // Single step from IDLE.
        do_reset();
        rom[0] = 8'h9C;
`ifdef SINGLE_STEP_EN
        sb.push_back({4'h1, 4'h0, 8'h9C});
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_fetch", {29'd0, state_dbg}, 32'd1);
        cyc(); cyc();
        chk("step_exec", {31'd0, exec_en}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("step_idle", {29'd0, state_dbg}, 32'd0);
        end
        chk("step_pc", {20'd0, pc}, 32'h001);
`else
        step = 1'b1;
        cyc();
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("step_ignored", {29'd0, state_dbg}, 32'd0);
            cyc();
        end
        chk("step_pc", {20'd0, pc}, 32'h000);
`endif
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
